parallel_converter_n_to_1: RTL and testbench
============================================

Name: parallel_converter_n_to_1

Overview:
- Inverse of the 1-to-N lane-gathering converter: accepts one wide bus word of N_LANES tagged blocks and serializes it into one tagged block per strobe.
- Sits on the TX side, after per-lane processing, where lane-parallel data must return to a single block stream.
- Bus packing: lane 0 occupies the most significant slice, bits [NB_DATA_BUS-1 -: NB_DATA_TAGGED]. Lane k occupies [NB_DATA_BUS-1-k*NB_DATA_TAGGED -: NB_DATA_TAGGED]. Lane 0 is emitted first.

Parameters:
- NB_DATA_TAGGED, 67, width of one tagged block.
- N_LANES, 20, blocks per bus word; must be ≥2.
- NB_DATA_BUS, NB_DATA_TAGGED*N_LANES, input bus width.
- NB_INDEX (localparam), $clog2(N_LANES), lane counter width.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global enable; low freezes all state.
- i_valid  in  1  block strobe; one output block per strobe.
- i_bus_valid  in  1  i_data holds a valid word.
- i_data  in  NB_DATA_BUS  lane-parallel input word.
- o_bus_ready  out  1  combinational; high in the cycle the bus is captured.
- o_valid  out  1  registered; output block valid.
- o_first  out  1  registered; o_data is lane 0 of a word.
- o_underflow  out  1  registered; one-cycle pulse, word expected but i_bus_valid low.
- o_data  out  NB_DATA_TAGGED  registered output block.

Behaviour:
- Definitions:
  - strobe = i_enable && i_valid.
  - State: IDLE (no word held) or RUN. Lane counter index runs 0..N_LANES-1.
  - Shift register shadow is NB_DATA_BUS wide.
- Reset values: state=IDLE, index=0, shadow=0, o_data=0, o_valid=0, o_first=0, o_underflow=0.
- Reset mid-word discards the remaining lanes. The next word starts at lane 0.
- o_bus_ready = strobe && (index==0).
- Capture (strobe, index==0, i_bus_valid=1):
  - shadow <= i_data shifted left by NB_DATA_TAGGED; lane 0 is consumed directly.
  - o_data <= top slice of i_data; o_valid <= 1, o_first <= 1.
  - index <= 1; state <= RUN.
- Missing word (strobe, index==0, i_bus_valid=0):
  - o_valid <= 0, o_first <= 0.
  - o_underflow <= 1 if state==RUN, otherwise 0.
  - state <= IDLE; index stays 0; o_data holds.
- Mid-word (strobe, index≠0):
  - o_data <= shadow top slice; shadow <= shadow << NB_DATA_TAGGED.
  - o_valid <= 1, o_first <= 0.
  - i_bus_valid and i_data are ignored.
- Wrap: if index==N_LANES-1, index <= 0, else index <= index+1.
  - A strobe in the cycle after the last lane must find i_bus_valid=1 for gapless streaming.
- No strobe: o_valid <= 0, o_first <= 0, o_underflow <= 0. index, shadow and o_data hold.
- i_enable=0 behaves as no strobe, regardless of i_valid.
- Latency: lane k of a captured word appears on o_data one clock after the k-th strobe following capture; capture strobe is k=0.
- Strobes need not be consecutive. Gaps only stretch the sequence.
- Lane order is independent of gap pattern.

Decomposition:
- Shared package holds defaults for NB_DATA_TAGGED (67), NB_DATA_CODED (66) and N_LANES (20). Both converter directions import them.
- Optional lane-slice helper function goes in the same package.
- No sub-module: one counter, one shift register and a two-state flag fit in one file.

Test Plan:
- Reset release, N_LANES=20, continuous strobe, word with lane k = k+1:
  - o_bus_ready high on the first strobe.
  - o_data = 1,2,…,20 on 20 consecutive cycles; o_first only with 1.
  - o_bus_ready high again on strobe 21.
- Back-to-back words A then B, i_bus_valid always high:
  - 40 gapless blocks, A lanes 0..19 then B lanes 0..19.
  - o_first at blocks 0 and 20; o_underflow never asserted.
- Strobe with i_valid toggling 1,0,1,0:
  - Same 20-value sequence.
  - o_valid high only on cycles following a strobe.
  - i_data changed mid-word does not affect output.
- After word A completes, i_bus_valid=0 on the next strobe:
  - o_underflow pulses one cycle; o_valid=0.
  - A later strobe with i_bus_valid=1 emits the new lane 0 with o_first=1.
  - Strobe in IDLE with i_bus_valid=0 gives no underflow.
- i_reset asserted after lane 7 emitted:
  - All outputs 0 next cycle.
  - After release, a new word starts at lane 0; no leftover lanes 8..19 appear.
- i_enable=0 for 5 cycles mid-word with i_valid=1:
  - Outputs frozen, o_valid=0.
  - Resumes at the next lane; no lane skipped or repeated.

Source files
------------

// File: rtl/parallel_converter_n_to_1_pkg.sv
// Shared defaults for the lane converters (both directions) and the
// word-presence state type used by the N-to-1 serializer.
package parallel_converter_n_to_1_pkg;

  localparam int NB_DATA_TAGGED_DEF = 67;
  localparam int NB_DATA_CODED_DEF  = 66;
  localparam int N_LANES_DEF        = 20;

  // IDLE: no word held; RUN: a word has been captured and is being emitted.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } conv_state_t;

endpackage

// File: rtl/parallel_converter_n_to_1.sv
// N-to-1 lane serializer: captures one bus word of N_LANES tagged blocks
// and emits one block per strobe, lane 0 (most significant slice) first.
module parallel_converter_n_to_1
  import parallel_converter_n_to_1_pkg::*;
#(
  parameter int NB_DATA_TAGGED = NB_DATA_TAGGED_DEF,
  parameter int N_LANES        = N_LANES_DEF,
  parameter int NB_DATA_BUS    = NB_DATA_TAGGED * N_LANES
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic                      i_bus_valid,
  input  logic [NB_DATA_BUS-1:0]    i_data,
  output logic                      o_bus_ready,
  output logic                      o_valid,
  output logic                      o_first,
  output logic                      o_underflow,
  output logic [NB_DATA_TAGGED-1:0] o_data
);

  localparam int                  NB_INDEX   = $clog2(N_LANES);
  localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(N_LANES - 1);

  conv_state_t               state_q, state_d;
  logic [NB_INDEX-1:0]       index_q, index_d;
  logic [NB_DATA_BUS-1:0]    shadow_q, shadow_d;
  logic [NB_DATA_TAGGED-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      first_q, first_d;
  logic                      underflow_q, underflow_d;

  logic                      strobe;
  logic                      at_word_start;
  logic [NB_INDEX-1:0]       index_next;

  assign strobe        = i_enable && i_valid;
  assign at_word_start = (index_q == '0);
  assign index_next    = (index_q == LAST_INDEX) ? '0 : index_q + NB_INDEX'(1);
  assign o_bus_ready   = strobe && at_word_start;

  // State register: remembers whether a word is (or was just) being emitted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only a word-start strobe can change the word-presence state.
  always_comb begin
    state_d = state_q;
    if (strobe && at_word_start) begin
      state_d = i_bus_valid ? ST_RUN : ST_IDLE;
    end
  end

  // Datapath registers: lane counter, shadow shift register and output block.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      index_q     <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      index_q     <= index_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      underflow_q <= underflow_d;
    end
  end

  // Output/datapath next values. Lane 0 bypasses the shadow on capture, so
  // the shadow is loaded already shifted by one lane.
  always_comb begin
    index_d     = index_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    underflow_d = 1'b0;
    if (strobe) begin
      if (at_word_start) begin
        if (i_bus_valid) begin
          shadow_d = i_data << NB_DATA_TAGGED;
          data_d   = i_data[NB_DATA_BUS-1 -: NB_DATA_TAGGED];
          valid_d  = 1'b1;
          first_d  = 1'b1;
          index_d  = index_next;
        end else begin
          underflow_d = (state_q == ST_RUN);
        end
      end else begin
        shadow_d = shadow_q << NB_DATA_TAGGED;
        data_d   = shadow_q[NB_DATA_BUS-1 -: NB_DATA_TAGGED];
        valid_d  = 1'b1;
        index_d  = index_next;
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_first     = first_q;
  assign o_underflow = underflow_q;
  assign o_data      = data_q;

endmodule

// File: tb/tb_parallel_converter_n_to_1.sv
// Self-checking bench for parallel_converter_n_to_1: queue-based reference
// model compared every cycle, plus literal expectations on directed scenarios.
module tb_parallel_converter_n_to_1;

  localparam int NB_T   = 67;
  localparam int NL     = 20;
  localparam int NB_BUS = NB_T * NL;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_enable = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_bus_valid = 1'b0;
  logic [NB_BUS-1:0] i_data = '0;
  logic              o_bus_ready;
  logic              o_valid;
  logic              o_first;
  logic              o_underflow;
  logic [NB_T-1:0]   o_data;

  always #5 i_clock = ~i_clock;

  parallel_converter_n_to_1 #(
    .NB_DATA_TAGGED(NB_T),
    .N_LANES(NL),
    .NB_DATA_BUS(NB_BUS)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_valid(i_valid),
    .i_bus_valid(i_bus_valid),
    .i_data(i_data),
    .o_bus_ready(o_bus_ready),
    .o_valid(o_valid),
    .o_first(o_first),
    .o_underflow(o_underflow),
    .o_data(o_data)
  );

  int checks = 0;
  int errors = 0;
  bit checks_on = 1'b0;
  bit last_ready;
  int uf_count = 0;

  logic [NB_T-1:0] log_q[$];
  bit              logf_q[$];
  logic [NB_T-1:0] lanes[2][NL];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes a queue of pending lanes; each strobe
  // pops one. An empty queue on a strobe means a new word is needed.
  logic [NB_T-1:0] pend_q[$];
  bit              held = 1'b0;
  logic [NB_T-1:0] m_data = '0;
  bit              m_valid = 1'b0;
  bit              m_first = 1'b0;
  bit              m_uf = 1'b0;

  always @(posedge i_clock) begin
    if (i_reset) begin
      pend_q.delete();
      held = 1'b0;
      m_data = '0;
      m_valid = 1'b0;
      m_first = 1'b0;
      m_uf = 1'b0;
    end else if (i_enable && i_valid) begin
      if (pend_q.size() == 0) begin
        if (i_bus_valid) begin
          for (int k = 0; k < NL; k++) pend_q.push_back(i_data[NB_BUS-1-k*NB_T -: NB_T]);
          m_data = pend_q.pop_front();
          m_valid = 1'b1;
          m_first = 1'b1;
          m_uf = 1'b0;
          held = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_first = 1'b0;
          m_uf = held;
          held = 1'b0;
        end
      end else begin
        m_data = pend_q.pop_front();
        m_valid = 1'b1;
        m_first = 1'b0;
        m_uf = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
      m_first = 1'b0;
      m_uf = 1'b0;
    end
  end

  // Per-cycle compare of registered outputs, plus a log of emitted blocks.
  always @(posedge i_clock) begin
    #1;
    if (checks_on) begin
      check("o_valid", o_valid, m_valid);
      check("o_first", o_first, m_first);
      check("o_underflow", o_underflow, m_uf);
      check("o_data", o_data, m_data);
      if (o_valid) begin
        log_q.push_back(o_data);
        logf_q.push_back(o_first);
      end
      if (o_underflow) uf_count++;
    end
  end

  function automatic logic [NB_T-1:0] rand_lane();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NB_T-1:0];
  endfunction

  function automatic logic [NB_BUS-1:0] pack(input int s);
    logic [NB_BUS-1:0] w;
    w = '0;
    for (int k = 0; k < NL; k++) w[NB_BUS-1-k*NB_T -: NB_T] = lanes[s][k];
    return w;
  endfunction

  function automatic logic [NB_BUS-1:0] rand_bus();
    logic [NB_BUS-1:0] w;
    w = '0;
    for (int k = 0; k < NL; k++) w[NB_BUS-1-k*NB_T -: NB_T] = rand_lane();
    return w;
  endfunction

  task automatic randomize_lanes(input int s);
    for (int k = 0; k < NL; k++) lanes[s][k] = rand_lane();
  endtask

  // One clock cycle of stimulus; also checks the combinational ready.
  task automatic cyc(input bit en, input bit v, input bit bv,
                     input logic [NB_BUS-1:0] d, input bit rst = 1'b0);
    @(negedge i_clock);
    i_reset = rst;
    i_enable = en;
    i_valid = v;
    i_bus_valid = bv;
    i_data = d;
    #2;
    if (checks_on) check("o_bus_ready", o_bus_ready, en && v && (pend_q.size() == 0));
    last_ready = o_bus_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_log();
    log_q.delete();
    logf_q.delete();
  endtask

  task automatic check_log_word(input string name, input int s, input int base);
    for (int k = 0; k < NL; k++) begin
      if (base + k < log_q.size()) begin
        check(name, log_q[base+k], lanes[s][k]);
        check({name, "_first"}, logf_q[base+k], k == 0);
      end else begin
        check({name, "_missing"}, log_q.size(), base + k + 1);
      end
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks_on = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("reset_o_data", o_data, 0);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_first", o_first, 0);
    check("reset_o_underflow", o_underflow, 0);

    // Counting word, continuous strobes, ready on strobe 1 and 21.
    for (int k = 0; k < NL; k++) lanes[0][k] = NB_T'(k + 1);
    clear_log();
    cyc(1'b1, 1'b1, 1'b1, pack(0));
    check("ready_strobe1", last_ready, 1);
    for (int i = 1; i < NL; i++) begin
      cyc(1'b1, 1'b1, 1'b1, pack(0));
      if (i == 1) check("ready_strobe2", last_ready, 0);
    end
    cyc(1'b1, 1'b1, 1'b1, pack(0));
    check("ready_strobe21", last_ready, 1);
    idle(2);
    check("count_log_size", log_q.size(), NL + 1);
    for (int k = 0; k < NL; k++) begin
      check("count_lane", log_q[k], k + 1);
      check("count_first", logf_q[k], k == 0);
    end
    check("count_next_lane0", log_q[NL], 1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Back-to-back words A then B.
    randomize_lanes(0);
    randomize_lanes(1);
    clear_log();
    uf_count = 0;
    for (int i = 0; i < 2 * NL; i++) cyc(1'b1, 1'b1, 1'b1, pack(i < NL ? 0 : 1));
    idle(2);
    check("b2b_log_size", log_q.size(), 2 * NL);
    check_log_word("b2b_A", 0, 0);
    check_log_word("b2b_B", 1, NL);
    check("b2b_underflow", uf_count, 0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Alternating strobes with noisy i_data mid-word.
    randomize_lanes(0);
    clear_log();
    for (int i = 0; i < 2 * NL; i++)
      cyc(1'b1, (i % 2) == 0, (i == 0) ? 1'b1 : 1'($urandom), (i == 0) ? pack(0) : rand_bus());
    idle(2);
    check("gap_log_size", log_q.size(), NL);
    check_log_word("gap", 0, 0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Underflow after a completed word; none in IDLE; recovery.
    randomize_lanes(0);
    randomize_lanes(1);
    uf_count = 0;
    for (int i = 0; i < NL; i++) cyc(1'b1, 1'b1, 1'b1, pack(0));
    cyc(1'b1, 1'b1, 1'b0, rand_bus());
    idle(1);
    check("uf_pulse_count", uf_count, 1);
    cyc(1'b1, 1'b1, 1'b0, rand_bus());
    idle(1);
    check("uf_idle_none", uf_count, 1);
    clear_log();
    cyc(1'b1, 1'b1, 1'b1, pack(1));
    idle(2);
    check("uf_recover_size", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("uf_recover_lane0", log_q[0], lanes[1][0]);
      check("uf_recover_first", logf_q[0], 1);
    end
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Reset mid-word after lane 7.
    randomize_lanes(0);
    randomize_lanes(1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, pack(0));
    cyc(1'b1, 1'b1, 1'b1, pack(0), 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_data", o_data, 0);
    check("midrst_o_first", o_first, 0);
    clear_log();
    for (int i = 0; i < NL; i++) cyc(1'b1, 1'b1, 1'b1, pack(1));
    idle(2);
    check("midrst_log_size", log_q.size(), NL);
    check_log_word("midrst", 1, 0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Enable low for 5 cycles mid-word with i_valid high.
    randomize_lanes(0);
    clear_log();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, pack(0));
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, rand_bus());
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, rand_bus());
    idle(2);
    check("enable_log_size", log_q.size(), NL);
    check_log_word("enable", 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 5) != 0, rand_bus(), $urandom_range(0, 199) == 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
